// File: rtl/mem_port_pkg.sv
// mem_port_pkg: FSM state encoding and response FIFO depth shared by the memory port initiator
package mem_port_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam int RSP_DEPTH = 2;
endpackage

// File: rtl/mem_port_rsp_fifo.sv
// mem_port_rsp_fifo: 2-entry response buffer with push/pop/count and 1-bit wrapping pointers
module mem_port_rsp_fifo #(
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);
  import mem_port_pkg::*;
  logic [DATA_W-1:0] r_mem [RSP_DEPTH];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  // storage, pointers and occupancy; the caller never pushes into a full buffer without popping
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_mem   <= '{default: '0};
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push) r_mem[r_wptr] <= din;
      r_wptr  <= r_wptr ^ push;
      r_rptr  <= r_rptr ^ pop;
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  assign dout  = r_mem[r_rptr];
  assign count = r_count;
endmodule

// File: rtl/mem_port_initiator.sv
// mem_port_initiator: valid/ready request front end for one RAM macro port; MEM_PORT_INITIATOR_INIT_EN adds a zero-fill INIT phase
module mem_port_initiator #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);
  import mem_port_pkg::*;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_inflight;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_pop;
  logic              w_acc;
  logic              w_init_wr;
  logic              w_init_last;
  logic [ADDR_W-1:0] w_init_addr;
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("DEPTH must be in 1..2**ADDR_W");
  end
`ifdef MEM_PORT_INITIATOR_INIT_EN
  logic [ADDR_W-1:0] r_init_cnt;
  // zero-fill address walks 0..DEPTH-1, one word per INIT cycle
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_init_cnt <= '0;
    else if (r_state == INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
  assign w_init_wr   = (r_state == INIT) && !RST;
  assign w_init_last = r_init_cnt == ADDR_W'(DEPTH - 1);
  assign w_init_addr = r_init_cnt;
`else
  assign w_init_wr   = 1'b0;
  assign w_init_last = 1'b1;
  assign w_init_addr = '0;
`endif
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= INIT;
    else r_state <= w_state_nxt;
  // leave INIT once the last init word has been written (immediately when zero-fill is absent)
  always_comb w_state_nxt = (r_state == INIT && w_init_last) ? RUN : r_state;
  // credit check: buffered plus in-flight responses, net of this cycle's pop, must leave room for one more
  always_comb begin
    init_done = r_state == RUN;
    w_pop     = rsp_valid && rsp_ready;
    w_occ     = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    req_ready = init_done && (w_occ < 3'd2);
    w_acc     = req_valid && req_ready;
  end
  // RAM data is valid the cycle after a read accept and is captured into the FIFO then
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_inflight <= 1'b0;
    else r_inflight <= w_acc && !req_we;
  // memory port: accepted request wins, else init write, else fully idle
  always_comb begin
    CE  = w_acc || w_init_wr;
    WE  = w_acc ? req_we : w_init_wr;
    A   = w_acc ? req_addr : (w_init_wr ? w_init_addr : '0);
    D   = w_acc ? req_wdata : '0;
    WEM = w_acc ? req_wmask : {DATA_W{w_init_wr}};
  end
  mem_port_rsp_fifo #(.DATA_W(DATA_W)) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (r_inflight),
    .din   (Q),
    .pop   (w_pop),
    .dout  (rsp_rdata),
    .count (w_count)
  );
  assign rsp_valid = w_count != 2'd0;
endmodule

// File: tb/tb_mem_port_initiator.sv
// tb_mem_port_initiator: directed and random checks of mem_port_initiator against a RAM model and response scoreboard
module tb_mem_port_initiator;
  localparam int AW = 12;
  localparam int DW = 4;
  localparam int DEPTH = 16;
`ifdef MEM_PORT_INITIATOR_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif
  logic CLK = 0, RST = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, req_wmask = '0;
  logic req_ready, rsp_valid, init_done, CE, WE;
  logic [DW-1:0] rsp_rdata, WEM, D, Q;
  logic [AW-1:0] A;
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  typedef struct {logic [DW-1:0] d; int rc;} rsp_t;
  rsp_t pend[$];
  int n_checks = 0, n_pass = 0, n_fail = 0, cyc_n = 0, init_left = 0;
  bit run = 0;

  always #5 CLK = ~CLK;

  mem_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_done(init_done), .A(A), .CE(CE),
    .WE(WE), .WEM(WEM), .D(D), .Q(Q)
  );

  always @(posedge CLK)
    if (CE) begin
      if (WE) ram[A] <= (ram[A] & ~WEM) | (D & WEM);
      else Q <= ram[A];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(output bit acc);
    bit mv, pop, er, initw;
    logic [AW-1:0] ia;
    @(negedge CLK);
    mv = pend.size() > 0 && pend[0].rc <= cyc_n;
    pop = mv && rsp_ready;
    er = run && ((pend.size() - int'(pop)) < 2);
    acc = req_valid && er;
`ifdef MEM_PORT_INITIATOR_INIT_EN
    initw = !run;
`else
    initw = 0;
`endif
    ia = AW'(DEPTH - init_left);
    chk("req_ready", req_ready, er);
    chk("init_done", init_done, run);
    chk("rsp_valid", rsp_valid, mv);
    if (mv) chk("rsp_rdata", rsp_rdata, pend[0].d);
    chk("CE", CE, acc || initw);
    chk("WE", WE, acc ? req_we : initw);
    chk("A", A, acc ? req_addr : (initw ? ia : '0));
    chk("D", D, acc ? req_wdata : '0);
    chk("WEM", WEM, acc ? req_wmask : (initw ? 4'hF : 4'h0));
    if (pop) void'(pend.pop_front());
    if (acc && req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
    else if (acc) pend.push_back('{ref_mem[req_addr], cyc_n + 2});
    @(posedge CLK); #1;
    cyc_n++;
    if (!run) begin
      init_left--;
      if (init_left == 0) run = 1;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cyc(a);
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    bit acc;
    acc = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    for (int i = 0; i < 20 && !acc; i++) cyc(acc);
    chk("accept", acc, 1);
    req_valid = 0;
  endtask

  task automatic do_reset();
    bit a;
    int k;
    RST = 1; #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_CE", CE, 0);
    chk("rst_WE", WE, 0);
    chk("rst_A", A, 0);
    chk("rst_D", D, 0);
    chk("rst_WEM", WEM, 0);
    chk("rst_init_done", init_done, 0);
    req_valid = 0;
    pend.delete();
`ifdef MEM_PORT_INITIATOR_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 0; run = 0; init_left = INIT_CYC;
    k = 0;
    while (!init_done && k < 100) begin
      cyc(a);
      k++;
    end
    chk("init_len", k, INIT_CYC);
  endtask

  initial begin
    bit a;
    int n_acc;
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    #2;
    do_reset();
`ifdef MEM_PORT_INITIATOR_INIT_EN
    rsp_ready = 1;
    for (int i = 0; i < DEPTH; i++) issue(0, AW'(i), '0, '0);
    idle(3);
`endif
    rsp_ready = 0;
    issue(1, 12'h005, 4'hA, 4'hF);
    issue(0, 12'h005, 4'h0, 4'h0);
    chk("rd_latency", rsp_valid, 0);
    cyc(a);
    chk("wr_rd_valid", rsp_valid, 1);
    chk("wr_rd_data", rsp_rdata, 4'hA);
    rsp_ready = 1;
    idle(2);
    rsp_ready = 0;
    issue(1, 12'h005, 4'hF, 4'hF);
    issue(1, 12'h005, 4'h0, 4'h3);
    issue(0, 12'h005, 4'h0, 4'h0);
    cyc(a);
    chk("mask_data", rsp_rdata, 4'hC);
    rsp_ready = 1;
    idle(2);
    req_valid = 1; req_we = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      chk("b2b_ready", req_ready, 1);
      cyc(a);
    end
    req_valid = 0;
    idle(4);
    issue(1, 12'h010, 4'h0, 4'hF);
    issue(1, 12'h011, 4'h1, 4'hF);
    rsp_ready = 0; req_valid = 1; req_we = 0; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 12'h010 + AW'(n_acc);
      n_acc += int'(req_ready);
      cyc(a);
    end
    chk("stall_acc", n_acc, 2);
    chk("stall_ready", req_ready, 0);
    req_valid = 0;
    chk("drain0", rsp_rdata, 4'h0);
    rsp_ready = 1;
    cyc(a);
    chk("drain1", rsp_rdata, 4'h1);
    cyc(a);
    chk("restore_ready", req_ready, 1);
    idle(2);
    rsp_ready = 0;
    issue(0, 12'h003, 4'h0, 4'h0);
    cyc(a);
    issue(0, 12'h004, 4'h0, 4'h0);
    chk("pre_rst_valid", rsp_valid, 1);
    do_reset();
    rsp_ready = 1;
    idle(6);
    chk("no_stale", rsp_valid, 0);
    repeat (400) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom_range(0, 15));
      req_wdata = DW'($urandom);
      req_wmask = DW'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      cyc(a);
    end
    req_valid = 0; rsp_ready = 1;
    idle(6);
    chk("final_empty", rsp_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
